cronometro_control: RTL and testbench
=====================================

Name: cronometro_control

Overview:
- Sequencing controller for the countdown-timer/alarm path.
- Decodes PS/2 keyboard scancodes, qualified by got_data, to edit a BCD HH:MM:SS preset.
- Starts, pauses and clears the countdown, decrementing once per 1 s tick.
- Raises the alarm flag for a bounded time at 00:00:00; its outputs feed the timer registers, the alarm-flag logic and the VGA overlay.

Parameters:
- KEY_UP, 8'h75, scancode: increment selected field
- KEY_DOWN, 8'h72, scancode: decrement selected field
- KEY_LEFT, 8'h6B, scancode: select next-higher field (sec→min→hr→sec)
- KEY_RIGHT, 8'h74, scancode: select next-lower field (hr→min→sec→hr)
- KEY_START, 8'h1B, scancode 'S': start/pause toggle
- KEY_CLEAR, 8'h2D, scancode 'R': clear
- ALARM_SECS, 10, number of 1 s ticks the alarm flag stays high

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- got_data  input  1  one-cycle strobe; Tecla valid
- Tecla  input  8  PS/2 set-2 scancode byte
- tick_1s  input  1  one-cycle pulse every second
- Segundos  output  8  BCD seconds 00-59
- Minutos  output  8  BCD minutes 00-59
- Horas  output  8  BCD hours 00-23
- Campo  output  2  edit field: 0 sec, 1 min, 2 hr (3 never driven)
- Estado  output  2  0 EDIT, 1 RUN, 2 PAUSE, 3 ALARM
- Flag_Alarma  output  1  high only while in ALARM

Behaviour:
Reset
- All outputs and internal registers are cleared asynchronously when reset is low: Segundos/Minutos/Horas = 8'h00, Campo = 0, Estado = EDIT, Flag_Alarma = 0, break_pending = 0, alarm tick counter = 0.

Key qualification
- A key event is got_data = 1 with break_pending = 0 and Tecla ≠ 8'hF0.
- Tecla = 8'hF0 with got_data sets break_pending.
- The next got_data byte clears break_pending and is discarded (key releases are ignored).
- Extended prefix 8'hE0 is discarded silently.
- All actions take effect on the clock edge following the strobe (latency 1).
- Unrecognised codes produce no action.

States
- EDIT
  - UP/DOWN: modulo increment/decrement of the selected field in BCD, with wrap 59↔00 (sec, min) and 23↔00 (hr). No carry into other fields.
  - LEFT/RIGHT: rotate Campo.
  - START: → RUN, only if the time is nonzero; at 00:00:00 START is ignored.
  - CLEAR: zero all fields, Campo = 0.
  - tick_1s is ignored.
- RUN
  - On tick_1s: decrement HH:MM:SS by 1 with BCD borrow (sec 00→59 borrows from min; min 00→59 borrows from hr).
  - If the result is 00:00:00 → ALARM with the counter loaded to ALARM_SECS.
  - START → PAUSE. CLEAR → EDIT with time zeroed. Edit keys are ignored.
- PAUSE
  - tick_1s is ignored. START → RUN. CLEAR → EDIT zeroed. Edit keys are ignored.
- ALARM
  - Flag_Alarma = 1. Each tick_1s decrements the counter.
  - When the counter reaches 0 → EDIT.
  - Any key event → EDIT immediately.
  - Time stays 00:00:00. Exit leaves Flag_Alarma = 0 in the same cycle Estado becomes EDIT.

Simultaneous events
- tick and START in the same RUN cycle: the decrement is applied and the state → PAUSE, unless the decrement reaches zero, in which case ALARM wins.
- tick and CLEAR in the same cycle: CLEAR wins, so the time is zeroed.
- got_data during reset is ignored.
- Reset asserted mid-RUN or mid-ALARM returns everything to reset values with no residual flag.

Test Plan:
- Reset low, then high; send 75,75,F0,75 in EDIT → Segundos = 8'h02 (break pair ignored), Estado = 0.
- Campo = 0, Segundos = 00, send 72 → Segundos = 8'h59. Send 6B,6B to select hr; from 23 send 75 → Horas = 8'h00, Minutos unchanged.
- Preset 01:00:00, send 1B, one tick → 00:59:59, Estado = 1. Send 1B → Estado = 2; two ticks → still 00:59:59.
- Preset 00:00:02, RUN, two ticks → 00:00:00, Estado = 3, Flag_Alarma = 1. Ten more ticks → Estado = 0, Flag_Alarma = 0 on the 10th tick edge.
- In ALARM, send any key → Estado = 0 next cycle. At 00:00:00 in EDIT, send 1B → stays EDIT.
- RUN at 00:00:01 with tick and 1B strobe in the same cycle → ALARM. RUN at 00:10:00 with tick and 2D in the same cycle → EDIT, 00:00:00. Reset low mid-RUN → all outputs zero.

Source files
------------

// File: rtl/cronometro_control_if.sv
// Keyboard byte bus between the PS/2 receiver and the countdown controller.
//   got_data : one-cycle strobe, Tecla holds a valid scancode byte
//   Tecla    : PS/2 set-2 scancode byte
// master = the PS/2 receiver side (drives), slave = the controller (samples).
interface cronometro_control_if;
    logic       got_data;
    logic [7:0] Tecla;

    modport master (output got_data, output Tecla);
    modport slave  (input  got_data, input  Tecla);
endinterface

// File: rtl/cronometro_control.sv
// Countdown timer / alarm sequencing controller.
// Decodes PS/2 scancodes to edit a BCD HH:MM:SS preset, runs the countdown on
// tick_1s, and holds the alarm flag for ALARM_SECS ticks at 00:00:00.
// Ports:
//   clk         system clock
//   reset       asynchronous active-low reset
//   kbd         keyboard byte bus (got_data strobe + Tecla scancode)
//   tick_1s     one-cycle pulse per second
//   Segundos    BCD seconds 00-59
//   Minutos     BCD minutes 00-59
//   Horas       BCD hours 00-23
//   Campo       edit field: 0 sec, 1 min, 2 hr
//   Estado      0 EDIT, 1 RUN, 2 PAUSE, 3 ALARM
//   Flag_Alarma high only while in ALARM
module cronometro_control #(
    parameter logic [7:0]  KEY_UP     = 8'h75,
    parameter logic [7:0]  KEY_DOWN   = 8'h72,
    parameter logic [7:0]  KEY_LEFT   = 8'h6B,
    parameter logic [7:0]  KEY_RIGHT  = 8'h74,
    parameter logic [7:0]  KEY_START  = 8'h1B,
    parameter logic [7:0]  KEY_CLEAR  = 8'h2D,
    parameter int unsigned ALARM_SECS = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    cronometro_control_if.slave        kbd,
    input  logic                       tick_1s,
    output logic [7:0]                 Segundos,
    output logic [7:0]                 Minutos,
    output logic [7:0]                 Horas,
    output logic [1:0]                 Campo,
    output logic [1:0]                 Estado,
    output logic                       Flag_Alarma
);

    localparam int unsigned CntW = $clog2(ALARM_SECS + 1);

    typedef enum logic [1:0] {
        StEdit  = 2'd0,
        StRun   = 2'd1,
        StPause = 2'd2,
        StAlarm = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        sec_q, sec_d;
    logic [7:0]        min_q, min_d;
    logic [7:0]        hr_q, hr_d;
    logic [1:0]        campo_q, campo_d;
    logic              break_q, break_d;
    logic [CntW-1:0]   cnt_q, cnt_d;

    // Modulo BCD increment/decrement of a single field, wrapping at max.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        if (v >= max) begin
            return 8'h00;
        end else if (v[3:0] >= 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end else begin
            return v + 8'd1;
        end
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
        if (v == 8'h00) begin
            return max;
        end else if (v[3:0] == 4'd0) begin
            return {v[7:4] - 4'd1, 4'd9};
        end else begin
            return v - 8'd1;
        end
    endfunction

    // Key qualification: break code F0 and the byte after it are swallowed,
    // extended prefix E0 is never an event.
    logic key_valid;
    logic key_start;
    logic key_clear;

    always_comb begin
        key_valid = kbd.got_data && !break_q && (kbd.Tecla != 8'hF0) && (kbd.Tecla != 8'hE0);
        key_start = key_valid && (kbd.Tecla == KEY_START);
        key_clear = key_valid && (kbd.Tecla == KEY_CLEAR);
    end

    always_comb begin
        break_d = break_q;
        if (kbd.got_data) begin
            if (break_q) begin
                break_d = 1'b0;
            end else if (kbd.Tecla == 8'hF0) begin
                break_d = 1'b1;
            end
        end
    end

    // One-second decrement of the whole HH:MM:SS value with BCD borrow.
    logic [7:0] dec_sec, dec_min, dec_hr;
    logic       dec_zero;
    logic       time_zero;

    always_comb begin
        dec_sec = sec_q;
        dec_min = min_q;
        dec_hr  = hr_q;
        if (sec_q != 8'h00) begin
            dec_sec = bcd_dec(sec_q, 8'h59);
        end else begin
            dec_sec = 8'h59;
            if (min_q != 8'h00) begin
                dec_min = bcd_dec(min_q, 8'h59);
            end else begin
                dec_min = 8'h59;
                dec_hr  = bcd_dec(hr_q, 8'h23);
            end
        end
        dec_zero  = (dec_sec == 8'h00) && (dec_min == 8'h00) && (dec_hr == 8'h00);
        time_zero = (sec_q == 8'h00) && (min_q == 8'h00) && (hr_q == 8'h00);
    end

    // State register and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StEdit;
            sec_q   <= 8'h00;
            min_q   <= 8'h00;
            hr_q    <= 8'h00;
            campo_q <= 2'd0;
            break_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            hr_q    <= hr_d;
            campo_q <= campo_d;
            break_q <= break_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StEdit: begin
                if (key_start && !time_zero) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                // CLEAR beats a same-cycle tick; reaching zero beats START.
                if (key_clear) begin
                    state_d = StEdit;
                end else if (tick_1s && dec_zero) begin
                    state_d = StAlarm;
                end else if (key_start) begin
                    state_d = StPause;
                end
            end
            StPause: begin
                if (key_clear) begin
                    state_d = StEdit;
                end else if (key_start) begin
                    state_d = StRun;
                end
            end
            StAlarm: begin
                if (key_valid) begin
                    state_d = StEdit;
                end else if (tick_1s && (cnt_q <= CntW'(1))) begin
                    state_d = StEdit;
                end
            end
            default: state_d = StEdit;
        endcase
    end

    // Datapath next-value logic
    always_comb begin
        sec_d   = sec_q;
        min_d   = min_q;
        hr_d    = hr_q;
        campo_d = campo_q;
        cnt_d   = cnt_q;
        case (state_q)
            StEdit: begin
                if (key_valid) begin
                    if (kbd.Tecla == KEY_UP) begin
                        case (campo_q)
                            2'd0:    sec_d = bcd_inc(sec_q, 8'h59);
                            2'd1:    min_d = bcd_inc(min_q, 8'h59);
                            default: hr_d  = bcd_inc(hr_q, 8'h23);
                        endcase
                    end else if (kbd.Tecla == KEY_DOWN) begin
                        case (campo_q)
                            2'd0:    sec_d = bcd_dec(sec_q, 8'h59);
                            2'd1:    min_d = bcd_dec(min_q, 8'h59);
                            default: hr_d  = bcd_dec(hr_q, 8'h23);
                        endcase
                    end else if (kbd.Tecla == KEY_LEFT) begin
                        campo_d = (campo_q >= 2'd2) ? 2'd0 : campo_q + 2'd1;
                    end else if (kbd.Tecla == KEY_RIGHT) begin
                        campo_d = (campo_q == 2'd0) ? 2'd2 : campo_q - 2'd1;
                    end else if (kbd.Tecla == KEY_CLEAR) begin
                        sec_d   = 8'h00;
                        min_d   = 8'h00;
                        hr_d    = 8'h00;
                        campo_d = 2'd0;
                    end
                end
            end
            StRun: begin
                if (key_clear) begin
                    sec_d = 8'h00;
                    min_d = 8'h00;
                    hr_d  = 8'h00;
                end else if (tick_1s) begin
                    sec_d = dec_sec;
                    min_d = dec_min;
                    hr_d  = dec_hr;
                    if (dec_zero) begin
                        cnt_d = CntW'(ALARM_SECS);
                    end
                end
            end
            StPause: begin
                if (key_clear) begin
                    sec_d = 8'h00;
                    min_d = 8'h00;
                    hr_d  = 8'h00;
                end
            end
            StAlarm: begin
                if (key_valid) begin
                    cnt_d = '0;
                end else if (tick_1s && (cnt_q != '0)) begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: ;
        endcase
    end

    // Outputs
    always_comb begin
        Segundos    = sec_q;
        Minutos     = min_q;
        Horas       = hr_q;
        Campo       = campo_q;
        Estado      = state_q;
        Flag_Alarma = (state_q == StAlarm);
    end

endmodule

// File: tb/tb_cronometro_control.sv
module tb_cronometro_control;

    logic       clk;
    logic       reset;
    logic       tick_1s;
    logic [7:0] Segundos, Minutos, Horas;
    logic [1:0] Campo, Estado;
    logic       Flag_Alarma;

    int n_checks = 0;
    int n_pass   = 0;

    cronometro_control_if kbd ();

    cronometro_control dut (
        .clk         (clk),
        .reset       (reset),
        .kbd         (kbd),
        .tick_1s     (tick_1s),
        .Segundos    (Segundos),
        .Minutos     (Minutos),
        .Horas       (Horas),
        .Campo       (Campo),
        .Estado      (Estado),
        .Flag_Alarma (Flag_Alarma)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus; outputs are sampled at the following negedge.
    task automatic drive(input logic gd, input logic [7:0] code, input logic tk);
        @(negedge clk);
        kbd.got_data = gd;
        kbd.Tecla    = code;
        tick_1s      = tk;
        @(negedge clk);
        kbd.got_data = 1'b0;
        kbd.Tecla    = 8'h00;
        tick_1s      = 1'b0;
    endtask

    task automatic key(input logic [7:0] code);
        drive(1'b1, code, 1'b0);
    endtask

    task automatic tick();
        drive(1'b0, 8'h00, 1'b1);
    endtask

    task automatic check_time(input string tag, input logic [7:0] h, input logic [7:0] m,
                              input logic [7:0] s);
        check_eq({tag, "_hr"}, {24'd0, Horas}, {24'd0, h});
        check_eq({tag, "_min"}, {24'd0, Minutos}, {24'd0, m});
        check_eq({tag, "_sec"}, {24'd0, Segundos}, {24'd0, s});
    endtask

    initial begin
        reset        = 1'b0;
        kbd.got_data = 1'b1;   // strobe during reset must be ignored
        kbd.Tecla    = 8'h75;
        tick_1s      = 1'b0;
        repeat (3) @(negedge clk);
        check_time("rst", 8'h00, 8'h00, 8'h00);
        check_eq("rst_campo", 32'(Campo), 32'd0);
        check_eq("rst_estado", 32'(Estado), 32'd0);
        check_eq("rst_flag", 32'(Flag_Alarma), 32'd0);
        kbd.got_data = 1'b0;
        reset        = 1'b1;
        @(negedge clk);

        // Break pair F0 75 is swallowed
        key(8'h75); key(8'h75); key(8'hF0); key(8'h75);
        check_eq("brk_sec", 32'(Segundos), 32'h02);
        check_eq("brk_estado", 32'(Estado), 32'd0);
        key(8'h1C);            // unrecognised
        check_eq("unrec_sec", 32'(Segundos), 32'h02);

        // Field wraps
        key(8'h2D);
        check_time("clr", 8'h00, 8'h00, 8'h00);
        key(8'h72);
        check_eq("sec_wrap_dn", 32'(Segundos), 32'h59);
        key(8'h75);
        check_eq("sec_wrap_up", 32'(Segundos), 32'h00);
        key(8'h6B); key(8'h6B);
        check_eq("campo_hr", 32'(Campo), 32'd2);
        key(8'h72);
        check_eq("hr_wrap_dn", 32'(Horas), 32'h23);
        key(8'h75);
        check_eq("hr_wrap_up", 32'(Horas), 32'h00);
        check_eq("hr_wrap_min", 32'(Minutos), 32'h00);
        key(8'h6B);
        check_eq("campo_rot_l", 32'(Campo), 32'd0);
        key(8'h74);
        check_eq("campo_rot_r", 32'(Campo), 32'd2);
        key(8'h74);
        check_eq("campo_min", 32'(Campo), 32'd1);
        for (int i = 0; i < 10; i++) key(8'h75);
        check_eq("min_carry", 32'(Minutos), 32'h10);
        key(8'h72);
        check_eq("min_borrow", 32'(Minutos), 32'h09);
        key(8'hE0);
        check_eq("e0_ignored", 32'(Minutos), 32'h09);

        // Preset 01:00:00, run, pause
        key(8'h2D);
        check_eq("clr_campo", 32'(Campo), 32'd0);
        key(8'h6B); key(8'h6B); key(8'h75);
        key(8'h1B);
        check_eq("run_estado", 32'(Estado), 32'd1);
        tick();
        check_time("run_borrow", 8'h00, 8'h59, 8'h59);
        key(8'h1B);
        check_eq("pause_estado", 32'(Estado), 32'd2);
        tick(); tick();
        check_time("pause_hold", 8'h00, 8'h59, 8'h59);
        key(8'h75);
        check_time("pause_edit_ign", 8'h00, 8'h59, 8'h59);
        key(8'h1B);
        check_eq("resume_estado", 32'(Estado), 32'd1);
        tick();
        check_eq("resume_sec", 32'(Segundos), 32'h58);
        key(8'h2D);
        check_eq("run_clr_estado", 32'(Estado), 32'd0);
        check_time("run_clr", 8'h00, 8'h00, 8'h00);

        // Preset 00:00:02, count into ALARM, timeout after ten ticks
        key(8'h2D);
        key(8'h75); key(8'h75);
        key(8'h1B);
        tick();
        check_eq("cd_sec1", 32'(Segundos), 32'h01);
        tick();
        check_time("alarm_time", 8'h00, 8'h00, 8'h00);
        check_eq("alarm_estado", 32'(Estado), 32'd3);
        check_eq("alarm_flag", 32'(Flag_Alarma), 32'd1);
        repeat (9) tick();
        check_eq("alarm_9_estado", 32'(Estado), 32'd3);
        check_eq("alarm_9_flag", 32'(Flag_Alarma), 32'd1);
        tick();
        check_eq("alarm_10_estado", 32'(Estado), 32'd0);
        check_eq("alarm_10_flag", 32'(Flag_Alarma), 32'd0);

        // ALARM exit on key
        key(8'h75); key(8'h1B); tick();
        check_eq("alarm2_estado", 32'(Estado), 32'd3);
        key(8'h75);
        check_eq("alarm_key_estado", 32'(Estado), 32'd0);
        check_eq("alarm_key_flag", 32'(Flag_Alarma), 32'd0);
        check_eq("alarm_key_sec", 32'(Segundos), 32'h00);

        // START at zero is ignored
        key(8'h1B);
        check_eq("start_zero", 32'(Estado), 32'd0);

        // tick + START reaching zero: ALARM wins
        key(8'h75); key(8'h1B);
        drive(1'b1, 8'h1B, 1'b1);
        check_eq("tick_start_alarm", 32'(Estado), 32'd3);
        key(8'h2D);
        check_eq("alarm_clr_exit", 32'(Estado), 32'd0);

        // tick + START not at zero: decrement applied, PAUSE
        key(8'h75); key(8'h75); key(8'h1B);
        drive(1'b1, 8'h1B, 1'b1);
        check_eq("tick_start_pause", 32'(Estado), 32'd2);
        check_eq("tick_start_sec", 32'(Segundos), 32'h01);
        key(8'h2D);

        // tick + CLEAR: CLEAR wins
        key(8'h2D);
        key(8'h6B);
        for (int i = 0; i < 10; i++) key(8'h75);
        key(8'h1B);
        drive(1'b1, 8'h2D, 1'b1);
        check_eq("tick_clr_estado", 32'(Estado), 32'd0);
        check_time("tick_clr", 8'h00, 8'h00, 8'h00);

        // Reset mid-RUN
        key(8'h75);            // campo still min: 00:01:00
        key(8'h1B); tick();
        check_time("pre_rst", 8'h00, 8'h00, 8'h59);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check_eq("mid_rst_estado", 32'(Estado), 32'd0);
        check_time("mid_rst", 8'h00, 8'h00, 8'h00);
        check_eq("mid_rst_campo", 32'(Campo), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        check_eq("post_rst_estado", 32'(Estado), 32'd0);
        check_eq("post_rst_sec", 32'(Segundos), 32'h00);

        // Reset mid-ALARM leaves no flag
        key(8'h75); key(8'h1B); tick();
        check_eq("alarm3_flag", 32'(Flag_Alarma), 32'd1);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check_eq("alarm_rst_flag", 32'(Flag_Alarma), 32'd0);
        check_eq("alarm_rst_estado", 32'(Estado), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
